pwm_wave_out: RTL and testbench

//  Multi-channel PWM audio output stage. It sits between the CORDIC sine/cosine generator and the PMOD pins.

---
 rtl/pwm_wave_out.sv | 128 ++++++++++++
 tb/tb_pwm_wave_out.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_wave_out.sv
// Multi-channel PWM audio output stage: per-channel source select, attenuation and
// offset-binary conversion feeding an edge- or centre-aligned PWM with period-boundary duty reload.
module pwm_wave_out #(
    parameter int WIDTH      = 16,
    parameter int SAMPLE_MSB = 11,
    parameter int PWM_BITS   = 8,
    parameter int CHANNELS   = 2,
    parameter int FREQ_WIDTH = 12,
    parameter int PHASE_BITS = 16,
    parameter int LED_DIV    = 8
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [WIDTH-1:0]        sine,
    input  logic [WIDTH-1:0]        cosine,
    input  logic [FREQ_WIDTH-1:0]   freq,
    input  logic [2*CHANNELS-1:0]   wave_sel,
    input  logic [2*CHANNELS-1:0]   atten,
    input  logic                    center_mode,
    input  logic                    enable,
    output logic [CHANNELS-1:0]     pwm,
    output logic                    period_strobe,
    output logic                    pwm_led
);

    localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] SQ_HIGH = {1'b0, {(PWM_BITS-1){1'b1}}};
    localparam logic [PWM_BITS-1:0] SQ_LOW  = {1'b1, {(PWM_BITS-1){1'b0}}};

    logic [PWM_BITS-1:0]        cnt;
    logic [PWM_BITS-1:0]        cnt_nx;
    logic                       dir_down;
    logic                       dir_down_nx;
    logic                       mode_act;
    logic                       boundary;
    logic [PHASE_BITS-1:0]      phase;
    logic [LED_DIV-1:0]         led_cnt;
    logic [PWM_BITS-1:0]        duty_act [CHANNELS];
    logic [PWM_BITS-1:0]        duty_new [CHANNELS];
    logic signed [PWM_BITS-1:0] src      [CHANNELS];
    logic signed [PWM_BITS-1:0] shifted  [CHANNELS];
    logic [CHANNELS-1:0]        pwm_nx;

    // Only a slice of each CORDIC word is used; the rest is deliberately ignored.
    logic unused_bits;
    assign unused_bits = ^{sine, cosine};

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            case (wave_sel[2*i +: 2])
                2'b00:   src[i] = sine[SAMPLE_MSB -: PWM_BITS];
                2'b01:   src[i] = cosine[SAMPLE_MSB -: PWM_BITS];
                2'b10:   src[i] = {~phase[PHASE_BITS-1], phase[PHASE_BITS-2 -: PWM_BITS-1]};
                default: src[i] = phase[PHASE_BITS-1] ? SQ_HIGH : SQ_LOW;
            endcase
            shifted[i]  = src[i] >>> atten[2*i +: 2];
            duty_new[i] = {~shifted[i][PWM_BITS-1], shifted[i][PWM_BITS-2:0]};
        end
    end

    // Edge mode wraps at CNT_MAX; centre mode turns at CNT_MAX and ends the period at 1.
    always_comb begin
        boundary    = 1'b0;
        cnt_nx      = cnt;
        dir_down_nx = dir_down;
        if (enable) begin
            if (!mode_act) begin
                cnt_nx   = cnt + 1'b1;
                boundary = (cnt == CNT_MAX);
            end else if (!dir_down) begin
                if (cnt == CNT_MAX) begin
                    cnt_nx      = cnt - 1'b1;
                    dir_down_nx = 1'b1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end else begin
                cnt_nx   = cnt - 1'b1;
                boundary = (cnt == CNT_ONE);
            end
            if (boundary) begin
                cnt_nx      = '0;
                dir_down_nx = 1'b0;
            end
        end
    end

    // The pwm flop is computed from next-cycle count and duty so it lines up with cnt.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_nx[i] = enable && (cnt_nx < (boundary ? duty_new[i] : duty_act[i]));
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt           <= '0;
            dir_down      <= 1'b0;
            mode_act      <= 1'b0;
            phase         <= '0;
            led_cnt       <= '0;
            pwm_led       <= 1'b0;
            period_strobe <= 1'b0;
            pwm           <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_act[i] <= '0;
            end
        end else begin
            cnt           <= cnt_nx;
            dir_down      <= dir_down_nx;
            period_strobe <= boundary;
            pwm           <= pwm_nx;
            if (boundary) begin
                mode_act <= center_mode;
                phase    <= phase + PHASE_BITS'(freq);
                led_cnt  <= led_cnt + 1'b1;
                if (led_cnt == {LED_DIV{1'b1}}) begin
                    pwm_led <= ~pwm_led;
                end
                for (int i = 0; i < CHANNELS; i++) begin
                    duty_act[i] <= duty_new[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_wave_out.sv
// Bench for pwm_wave_out: randomized periods checked by a period-level scoreboard,
// then directed enable-freeze and async-reset checks.
module tb_pwm_wave_out;
    localparam int W  = 34;
    localparam int NP = 262;

    logic        clock = 1'b0;
    logic        resetn = 1'b1;
    logic [15:0] sine = '0;
    logic [15:0] cosine = '0;
    logic [11:0] freq = '0;
    logic [3:0]  wave_sel = '0;
    logic [3:0]  atten = '0;
    logic        center_mode = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  pwm;
    logic        period_strobe;
    logic        pwm_led;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];

    pwm_wave_out dut (
        .clock(clock), .resetn(resetn), .sine(sine), .cosine(cosine), .freq(freq),
        .wave_sel(wave_sel), .atten(atten), .center_mode(center_mode), .enable(enable),
        .pwm(pwm), .period_strobe(period_strobe), .pwm_led(pwm_led)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: signed sample from the chosen source, shifted, re-biased to 0..255.
    function automatic int ref_duty(input int sel, input int sh, input int s, input int c, input int ph);
        int v;
        case (sel)
            0:       v = (s >> 4) & 255;
            1:       v = (c >> 4) & 255;
            2:       v = (ph >> 8) + 128;
            default: v = (ph >= 32768) ? 127 : 128;
        endcase
        if (v >= 128) v = v - 256;
        v = v >>> sh;
        return v + 128;
    endfunction

    function automatic int base_len(input int mode);
        return mode ? 510 : 256;
    endfunction

    function automatic logic [W-1:0] pack(input int led, input int mode, input int len, input int d1, input int d0);
        return {led[0], mode[0], len[15:0], d1[7:0], d0[7:0]};
    endfunction

    task automatic set_inputs();
        case ($urandom_range(0, 3))
            0:       sine = 16'h0800;
            1:       sine = 16'h07F0;
            2:       sine = 16'h0000;
            default: sine = 16'($urandom);
        endcase
        cosine      = 16'($urandom);
        freq        = 12'($urandom);
        wave_sel    = 4'($urandom);
        atten       = 4'($urandom);
        center_mode = ($urandom_range(0, 15) == 0);
    endtask

    // ---------------- monitor ----------------
    logic mon_on = 1'b0;
    int   m_len;
    int   m_led;
    int   m_hi[2];
    int   m_first[2];
    int   m_last[2];

    task automatic mon_clear();
        m_len = 0;
        for (int c = 0; c < 2; c++) begin
            m_hi[c] = 0;
            m_first[c] = -1;
            m_last[c] = 0;
        end
    endtask

    task automatic close_period();
        logic [W-1:0] e;
        int d, mode, len;
        if (exp_q.size() == 0) begin
            check("unexpected_period", 1, 0);
            return;
        end
        e = exp_q.pop_front();
        mode = int'(e[32]);
        len = int'(e[31:16]);
        check("period_len", m_len, len);
        check("led_level", m_led, int'(e[33]));
        for (int c = 0; c < 2; c++) begin
            d = (c == 0) ? int'(e[7:0]) : int'(e[15:8]);
            check(c == 0 ? "high_cnt0" : "high_cnt1", m_hi[c], mode ? ((d == 0) ? 0 : 2 * d - 1) : d);
            check(c == 0 ? "first_hi0" : "first_hi1", m_first[c], (d > 0) ? 0 : -1);
            check(c == 0 ? "last_lvl0" : "last_lvl1", m_last[c], (mode != 0 && d >= 2) ? 1 : 0);
        end
    endtask

    always @(negedge clock) begin
        if (mon_on) begin
            if (period_strobe) begin
                close_period();
                mon_clear();
            end
            if (m_len == 0) m_led = int'(pwm_led);
            for (int c = 0; c < 2; c++) begin
                if (pwm[c]) begin
                    m_hi[c]++;
                    if (m_first[c] < 0) m_first[c] = m_len;
                end
                m_last[c] = int'(pwm[c]);
            end
            m_len++;
        end
    end

    // ---------------- driver ----------------
    initial begin
        int phase_m, mode_m, new_mode, gap_n, gap_j, ngap_n, ngap_j, L, c1, c2, d0, d1, p1_hi;

        #2 resetn = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_pwm", pwm, 0);
        check("rst_strobe", period_strobe, 0);
        check("rst_led", pwm_led, 0);

        set_inputs();
        enable = 1'b1;
        phase_m = 0;
        mode_m = 0;
        new_mode = 0;
        gap_n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
        gap_j = $urandom_range(0, 254);
        ngap_n = 0;
        ngap_j = 0;
        exp_q.push_back(pack(0, 0, 256 + gap_n, 0, 0));

        @(posedge clock);
        #1 resetn = 1'b1;
        mon_clear();
        mon_on = 1'b1;

        for (int p = 0; p < NP; p++) begin
            L = base_len(mode_m) + gap_n;
            c1 = $urandom_range(0, L - 2);
            c2 = $urandom_range(c1 + 1, L - 1);
            for (int j = 0; j < L; j++) begin
                @(negedge clock);
                if (gap_n > 0 && j == gap_j) enable = 1'b0;
                if (gap_n > 0 && j == gap_j + gap_n) enable = 1'b1;
                if (j == c1) set_inputs();
                if (j == c2) begin
                    set_inputs();
                    d0 = ref_duty(int'(wave_sel[1:0]), int'(atten[1:0]), int'(sine), int'(cosine), phase_m);
                    d1 = ref_duty(int'(wave_sel[3:2]), int'(atten[3:2]), int'(sine), int'(cosine), phase_m);
                    new_mode = int'(center_mode);
                    ngap_n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
                    ngap_j = $urandom_range(0, base_len(new_mode) - 2);
                    if (p < NP - 1)
                        exp_q.push_back(pack(((p + 1) / 256) & 1, new_mode, base_len(new_mode) + ngap_n, d1, d0));
                end
            end
            phase_m = (phase_m + int'(freq)) & 16'hFFFF;
            mode_m = new_mode;
            gap_n = ngap_n;
            gap_j = ngap_j;
        end
        repeat (3) @(negedge clock);
        #1 check("queue_drained", exp_q.size(), 0);
        mon_on = 1'b0;

        // Directed: first period dark, enable freeze at cnt=100, async reset while high.
        @(negedge clock);
        resetn = 1'b0;
        enable = 1'b1;
        center_mode = 1'b0;
        wave_sel = 4'b0000;
        atten = 4'b0000;
        sine = 16'h07F0;
        #1 check("rst2_pwm", pwm, 0);
        @(posedge clock);
        #1 resetn = 1'b1;
        p1_hi = 0;
        for (int i = 0; i < 521; i++) begin
            @(negedge clock);
            if (i < 256 && pwm != 2'b00) p1_hi++;
            if (i == 255) check("first_period_dark", p1_hi, 0);
            if (i == 255) check("no_early_strobe", period_strobe, 0);
            if (i == 256) check("strobe_at_256", period_strobe, 1);
            if (i == 266) check("full_duty_high", pwm, 2'b11);
            if (i >= 357 && i <= 361) check("frozen_low", pwm, 2'b00);
            if (i == 362) check("resume_high", pwm, 2'b11);
            if (i == 512) check("strobe_delayed", period_strobe, 0);
            if (i == 517) check("strobe_after_freeze", period_strobe, 1);
            if (i == 520) check("high_before_reset", pwm, 2'b11);
            if (i == 356) enable = 1'b0;
            if (i == 361) enable = 1'b1;
        end
        resetn = 1'b0;
        #1;
        check("async_rst_pwm", pwm, 0);
        check("async_rst_strobe", period_strobe, 0);
        check("async_rst_led", pwm_led, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
